// File: rtl/imm_gen_pkg.sv
// Shared types and constants for the decode-stage immediate generator.
// Contents: imm_type_e codes, RV32/RV64 base opcodes, instruction width.
package imm_gen_pkg;

  localparam int unsigned INST_W = 32;
  localparam int unsigned TYPE_W = 3;
  localparam int unsigned OPC_W  = 7;

  typedef enum logic [TYPE_W-1:0] {
    IMM_NONE = 3'd0,
    IMM_I    = 3'd1,
    IMM_S    = 3'd2,
    IMM_B    = 3'd3,
    IMM_U    = 3'd4,
    IMM_J    = 3'd5,
    IMM_Z    = 3'd6
  } imm_type_e;

  localparam logic [OPC_W-1:0] OPC_OP     = 7'b0110011;
  localparam logic [OPC_W-1:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [OPC_W-1:0] OPC_LOAD   = 7'b0000011;
  localparam logic [OPC_W-1:0] OPC_STORE  = 7'b0100011;
  localparam logic [OPC_W-1:0] OPC_BRANCH = 7'b1100011;
  localparam logic [OPC_W-1:0] OPC_JAL    = 7'b1101111;
  localparam logic [OPC_W-1:0] OPC_JALR   = 7'b1100111;
  localparam logic [OPC_W-1:0] OPC_LUI    = 7'b0110111;
  localparam logic [OPC_W-1:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [OPC_W-1:0] OPC_SYSTEM = 7'b1110011;

endpackage

// File: rtl/imm_decode.sv
// Combinational opcode-to-immediate decode.
// Ports: inst_i (instruction word) -> imm_o (XLEN, extended immediate),
//        imm_type_o (imm_type_e code), unknown_o (opcode not recognised).
// Optional: IMM_CSR_EN enables the Z-type CSR immediate (CSRR*I).
module imm_decode
  import imm_gen_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic [INST_W-1:0] inst_i,
  output logic [XLEN-1:0]   imm_o,
  output logic [TYPE_W-1:0] imm_type_o,
  output logic              unknown_o
);

  // imm32 is already extended to 32 bits (sign for all types, zero for Z),
  // so a single sign extension of bit 31 widens every type correctly.
  logic [31:0] imm32;
  imm_type_e   imm_type;

  always_comb begin
    imm32     = '0;
    imm_type  = IMM_NONE;
    unknown_o = 1'b0;
    case (inst_i[OPC_W-1:0])
      OPC_OP: begin
        imm_type = IMM_NONE;
      end
      OPC_OPIMM, OPC_LOAD, OPC_JALR: begin
        imm_type = IMM_I;
        imm32    = {{20{inst_i[31]}}, inst_i[31:20]};
      end
      OPC_STORE: begin
        imm_type = IMM_S;
        imm32    = {{20{inst_i[31]}}, inst_i[31:25], inst_i[11:7]};
      end
      OPC_BRANCH: begin
        imm_type = IMM_B;
        imm32    = {{19{inst_i[31]}}, inst_i[31], inst_i[7], inst_i[30:25],
                    inst_i[11:8], 1'b0};
      end
      OPC_JAL: begin
        imm_type = IMM_J;
        imm32    = {{11{inst_i[31]}}, inst_i[31], inst_i[19:12], inst_i[20],
                    inst_i[30:21], 1'b0};
      end
      OPC_LUI, OPC_AUIPC: begin
        imm_type = IMM_U;
        imm32    = {inst_i[31:12], 12'b0};
      end
      OPC_SYSTEM: begin
`ifdef IMM_CSR_EN
        // funct3[2] selects the immediate CSR forms; rs1 field is the uimm
        if (inst_i[14]) begin
          imm_type = IMM_Z;
          imm32    = {27'b0, inst_i[19:15]};
        end else begin
          imm_type = IMM_I;
          imm32    = {{20{inst_i[31]}}, inst_i[31:20]};
        end
`else
        imm_type = IMM_I;
        imm32    = {{20{inst_i[31]}}, inst_i[31:20]};
`endif
      end
      default: begin
        imm_type  = IMM_I;
        imm32     = {{20{inst_i[31]}}, inst_i[31:20]};
        unknown_o = 1'b1;
      end
    endcase
  end

  assign imm_o      = XLEN'(signed'(imm32));
  assign imm_type_o = imm_type;

endmodule

// File: rtl/imm_gen_stage.sv
// Registered immediate generator with a 2-entry (main + skid) output buffer.
// Ports: clk, rst_n (async, active-low), flush_i;
//        in_valid_i/in_ready_o/inst_i/pc_i  - instruction input handshake;
//        out_valid_o/out_ready_i/imm_o/imm_type_o/inst_o/pc_o/unknown_o
//        - decoded result handshake, driven from the main entry.
// Optional: IMM_CSR_EN (see imm_decode) enables Z-type CSR immediates.
module imm_gen_stage
  import imm_gen_pkg::*;
#(
  parameter int unsigned XLEN = 32,
  parameter int unsigned PC_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [INST_W-1:0] inst_i,
  input  logic [PC_W-1:0]   pc_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [XLEN-1:0]   imm_o,
  output logic [TYPE_W-1:0] imm_type_o,
  output logic [INST_W-1:0] inst_o,
  output logic [PC_W-1:0]   pc_o,
  output logic              unknown_o
);

  typedef struct packed {
    logic [XLEN-1:0]   imm;
    logic [TYPE_W-1:0] imm_type;
    logic [INST_W-1:0] inst;
    logic [PC_W-1:0]   pc;
    logic              unknown;
  } entry_t;

  entry_t main_q, main_d, skid_q, skid_d, in_entry;
  logic   main_v_q, main_v_d, skid_v_q, skid_v_d;
  logic   accept, drain;

  logic [XLEN-1:0]   dec_imm;
  logic [TYPE_W-1:0] dec_type;
  logic              dec_unknown;

  imm_decode #(.XLEN(XLEN)) u_decode (
    .inst_i     (inst_i),
    .imm_o      (dec_imm),
    .imm_type_o (dec_type),
    .unknown_o  (dec_unknown)
  );

  // Incoming entry assembled from the decode plus sideband
  always_comb begin
    in_entry          = '0;
    in_entry.imm      = dec_imm;
    in_entry.imm_type = dec_type;
    in_entry.inst     = inst_i;
    in_entry.pc       = pc_i;
    in_entry.unknown  = dec_unknown;
  end

  // Ready depends only on registered state, so out_ready_i never reaches it
  assign accept = in_valid_i & ~skid_v_q;
  assign drain  = main_v_q & out_ready_i;

  // Buffer next state; flush overrides both accept and drain
  always_comb begin
    main_d   = main_q;
    skid_d   = skid_q;
    main_v_d = main_v_q;
    skid_v_d = skid_v_q;
    if (flush_i) begin
      main_v_d = 1'b0;
      skid_v_d = 1'b0;
    end else begin
      if (drain) begin
        if (skid_v_q) begin
          main_d   = skid_q;
          main_v_d = 1'b1;
        end else begin
          main_v_d = 1'b0;
        end
        skid_v_d = 1'b0;
      end
      // New entry lands in main if it is (or is becoming) free, else skid
      if (accept) begin
        if (!main_v_d) begin
          main_d   = in_entry;
          main_v_d = 1'b1;
        end else begin
          skid_d   = in_entry;
          skid_v_d = 1'b1;
        end
      end
    end
  end

  // Buffer state registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_q   <= '0;
      skid_q   <= '0;
      main_v_q <= 1'b0;
      skid_v_q <= 1'b0;
    end else begin
      main_q   <= main_d;
      skid_q   <= skid_d;
      main_v_q <= main_v_d;
      skid_v_q <= skid_v_d;
    end
  end

  assign in_ready_o  = ~skid_v_q;
  assign out_valid_o = main_v_q;
  assign imm_o       = main_q.imm;
  assign imm_type_o  = main_q.imm_type;
  assign inst_o      = main_q.inst;
  assign pc_o        = main_q.pc;
  assign unknown_o   = main_q.unknown;

endmodule
